ofb_tea: RTL and testbench



---
 rtl/ofb_tea_pkg.sv | 10 +
 rtl/tea_encrypt.sv | 35 +++
 rtl/ofb_tea.sv | 33 +++
 tb/tb_ofb_tea.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ofb_tea_pkg.sv
// Shared constants for the TEA-based OFB keystream block.
// Imported by the cipher core and the OFB wrapper.
package ofb_tea_pkg;

    localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;
    localparam int          TEA_ROUNDS = 32;
    localparam int          BLOCK_W    = 64;
    localparam int          KEY_W      = 128;

endpackage

// File: rtl/tea_encrypt.sv
// Fully unrolled combinational TEA encryption of one 64-bit block.
// Each generate stage is one TEA cycle (two Feistel half-rounds).
module tea_encrypt
    import ofb_tea_pkg::*;
(
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] block_in,
    output logic [BLOCK_W-1:0] block_out
);

    logic [31:0] k0, k1, k2, k3;
    logic [TEA_ROUNDS:0][31:0] v0;
    logic [TEA_ROUNDS:0][31:0] v1;

    assign k0 = key[127:96];
    assign k1 = key[95:64];
    assign k2 = key[63:32];
    assign k3 = key[31:0];

    assign v0[0] = block_in[63:32];
    assign v1[0] = block_in[31:0];

    for (genvar i = 0; i < TEA_ROUNDS; i++) begin : g_cycle
        // Running sum is a per-stage constant, so no adder chain for it.
        localparam logic [31:0] SUM = TEA_DELTA * 32'(i + 1);

        assign v0[i+1] = v0[i]
            + (((v1[i] << 4) + k0) ^ (v1[i] + SUM) ^ ((v1[i] >> 5) + k1));
        assign v1[i+1] = v1[i]
            + (((v0[i+1] << 4) + k2) ^ (v0[i+1] + SUM) ^ ((v0[i+1] >> 5) + k3));
    end

    assign block_out = {v0[TEA_ROUNDS], v1[TEA_ROUNDS]};

endmodule

// File: rtl/ofb_tea.sv
// OFB-mode TEA stream: feedback register encrypted every clock,
// keystream XORed with the incoming block; same path encrypts and decrypts.
module ofb_tea
    import ofb_tea_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] iv,
    output logic [BLOCK_W-1:0] data_out
);

    logic [BLOCK_W-1:0] fb;
    logic [BLOCK_W-1:0] ks;

    tea_encrypt u_tea (
        .key       (key),
        .block_in  (fb),
        .block_out (ks)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb       <= iv;
            data_out <= '0;
        end else begin
            fb       <= ks;
            data_out <= data_in ^ ks;
        end
    end

endmodule

// File: tb/tb_ofb_tea.sv
// Bench for ofb_tea: known answers, chaining, round trip, restart,
// key change and a randomized stream against a software TEA model.
module tb_ofb_tea;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  data_in = '0;
    logic [127:0] key = '0;
    logic [63:0]  iv = '0;
    logic [63:0]  data_out;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] K  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [63:0]  IV = 64'h0123456789ABCDEF;

    ofb_tea dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .key      (key),
        .iv       (iv),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tea(input logic [127:0] k,
                                        input logic [63:0] x);
        logic [31:0] a = x[63:32];
        logic [31:0] b = x[31:0];
        logic [31:0] s = 32'd0;
        for (int r = 0; r < 32; r++) begin
            s = s + 32'h9E3779B9;
            a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
            b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
        end
        return {a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] v);
        iv = v;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        key = K;
        iv = IV;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (data_out !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_out: got %h want %h", data_out, 64'h0);
        end
        vectors++;
        if (dut.fb !== IV) begin
            miscompares++;
            $display("FAIL reset_fb: got %h want %h", dut.fb, IV);
        end
        reset = 1'b0;
    endtask

    task automatic test_kat();
        key = '0;
        data_in = '0;
        do_reset(64'h0);
        tick();
        vectors++;
        if (data_out !== 64'h41EA3A0A94BAA940) begin
            miscompares++;
            $display("FAIL kat_zero: got %h want %h",
                     data_out, 64'h41EA3A0A94BAA940);
        end
    endtask

    task automatic test_chain();
        logic [63:0] exp;
        key = K;
        data_in = '0;
        do_reset(IV);
        exp = IV;
        for (int n = 1; n <= 4; n++) begin
            exp = tea(K, exp);
            tick();
            vectors++;
            if (data_out !== exp) begin
                miscompares++;
                $display("FAIL chain_%0d: got %h want %h", n, data_out, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] iv2;
        iv2 = {$urandom, $urandom};
        data_in = {$urandom, $urandom};
        tick();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (data_out !== 64'h0) begin
            miscompares++;
            $display("FAIL async_reset_out: got %h want %h", data_out, 64'h0);
        end
        vectors++;
        if (dut.fb !== IV) begin
            miscompares++;
            $display("FAIL async_reset_fb: got %h want %h", dut.fb, IV);
        end
        iv = iv2;
        tick();
        vectors++;
        if (dut.fb !== iv2) begin
            miscompares++;
            $display("FAIL reset_track_iv: got %h want %h", dut.fb, iv2);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (data_out !== (data_in ^ tea(K, iv2))) begin
            miscompares++;
            $display("FAIL after_track: got %h want %h",
                     data_out, data_in ^ tea(K, iv2));
        end
    endtask

    task automatic test_round_trip();
        logic [63:0] pts [2];
        logic [63:0] c;
        pts[0] = 64'h0123456789ABCDEF;
        pts[1] = 64'h0011223344556677;
        key = K;
        for (int i = 0; i < 2; i++) begin
            data_in = pts[i];
            do_reset(IV);
            tick();
            c = data_out;
            vectors++;
            if (c !== (pts[i] ^ tea(K, IV))) begin
                miscompares++;
                $display("FAIL rt_enc_%0d: got %h want %h",
                         i, c, pts[i] ^ tea(K, IV));
            end
            data_in = c;
            do_reset(IV);
            tick();
            vectors++;
            if (data_out !== pts[i]) begin
                miscompares++;
                $display("FAIL rt_dec_%0d: got %h want %h",
                         i, data_out, pts[i]);
            end
        end
    endtask

    task automatic test_restart();
        logic [63:0] blk [2];
        blk[0] = 64'hAD463072D1CA97FB;
        blk[1] = 64'hAC7457261C343C63;
        key = K;
        for (int i = 0; i < 2; i++) begin
            data_in = blk[i];
            do_reset(IV);
            tick();
            vectors++;
            if (data_out !== (blk[i] ^ tea(K, IV))) begin
                miscompares++;
                $display("FAIL restart_%0d: got %h want %h",
                         i, data_out, blk[i] ^ tea(K, IV));
            end
        end
    endtask

    task automatic test_key_change();
        logic [127:0] k2;
        logic [127:0] kcur;
        logic [63:0]  fbm;
        logic [63:0]  exp;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        key = K;
        kcur = K;
        do_reset(IV);
        fbm = IV;
        for (int n = 1; n <= 5; n++) begin
            if (n == 3) begin
                key = k2;
                kcur = k2;
            end
            data_in = {$urandom, $urandom};
            fbm = tea(kcur, fbm);
            exp = data_in ^ fbm;
            tick();
            vectors++;
            if (data_out !== exp) begin
                miscompares++;
                $display("FAIL keychg_%0d: got %h want %h", n, data_out, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] fbm;
        logic [63:0] exp;
        key = {$urandom, $urandom, $urandom, $urandom};
        do_reset({$urandom, $urandom});
        fbm = iv;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_reset({$urandom, $urandom});
                fbm = iv;
            end
            if ($urandom_range(0, 7) == 0)
                key = {$urandom, $urandom, $urandom, $urandom};
            data_in = {$urandom, $urandom};
            fbm = tea(key, fbm);
            exp = data_in ^ fbm;
            tick();
            vectors++;
            if (data_out !== exp) begin
                miscompares++;
                $display("FAIL random_%0d: got %h want %h", n, data_out, exp);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_kat();
        test_chain();
        test_async_reset();
        test_round_trip();
        test_restart();
        test_key_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
